// File: rtl/sid_bus_arbiter_pkg.sv
// Shared types for the SID write-port arbiter: bus/aux payload structs,
// arbiter state encoding and the voice-cycle window used for injections.
package sid_bus_arbiter_pkg;

    typedef logic [7:0] reg8_t;
    typedef logic [3:0] cycle_t;

    typedef struct packed {
        logic       phi2;
        logic       res;
        logic       r_w_n;
        logic [4:0] addr;
        reg8_t      data;
    } bus_i_t;

    typedef struct packed {
        logic       chip;
        logic [4:0] addr;
        reg8_t      data;
    } aux_wr_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_INJECT = 1'b1
    } arb_state_t;

    localparam cycle_t SLOT_START = 4'd0;
    localparam cycle_t INJ_FIRST  = 4'd1;
    localparam cycle_t INJ_LAST   = 4'd6;

    // True while voice_cycle is inside the window where an injected write is held.
    function automatic logic in_inject_window(input cycle_t vc);
        return (vc >= INJ_FIRST) && (vc <= INJ_LAST);
    endfunction

    // One-hot chip select for the addressed SID.
    function automatic logic [1:0] chip_cs(input logic chip);
        return chip ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sid_bus_arbiter_if.sv
// Bundle of the CPU bus, aux write handshake and arbitrated outputs.
// The master side drives the CPU/aux inputs; the arbiter is the slave.
interface sid_bus_arbiter_if;
    import sid_bus_arbiter_pkg::*;

    cycle_t      voice_cycle;
    bus_i_t      cpu_bus_i;
    logic [1:0]  cpu_cs;
    logic        aux_valid;
    logic        aux_ready;
    aux_wr_t     aux_wr;
    bus_i_t      bus_o;
    logic [1:0]  cs_o;
    logic        busy;
    logic [7:0]  preempt_cnt;

    modport master (
        output voice_cycle, cpu_bus_i, cpu_cs, aux_valid, aux_wr,
        input  aux_ready, bus_o, cs_o, busy, preempt_cnt
    );

    modport slave (
        input  voice_cycle, cpu_bus_i, cpu_cs, aux_valid, aux_wr,
        output aux_ready, bus_o, cs_o, busy, preempt_cnt
    );

endinterface

// File: rtl/sid_aux_fifo.sv
// Synchronous FIFO for queued aux register writes. Pushes while full and
// pops while empty are ignored; the head entry is always visible.
module sid_aux_fifo
    import sid_bus_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  aux_wr_t wr_data,
    output logic    full,
    output logic    empty,
    output aux_wr_t head
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    aux_wr_t         mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sid_bus_arbiter.sv
// Arbiter for the SID register write port. The CPU bus always wins and
// passes straight through; queued aux writes are slipped into idle voice
// slots as phi2-low writes held over voice_cycle 1..6.
//
// state      | meaning
// ARB_IDLE   | CPU passthrough, waiting for a free slot at voice_cycle 0
// ARB_INJECT | head aux write driven onto the bus unless the CPU selects
module sid_bus_arbiter
    import sid_bus_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    sid_bus_arbiter_if.slave arb
);

    arb_state_t state;
    logic [7:0] preempt_q;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    aux_wr_t    head;
    logic       cpu_active;
    logic       slot_free;
    logic       in_window;
    logic       override;

    sid_aux_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (arb.aux_valid),
        .pop     (fifo_pop),
        .wr_data (arb.aux_wr),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head)
    );

    assign cpu_active = |arb.cpu_cs;
    assign in_window  = in_inject_window(arb.voice_cycle);
    assign slot_free  = (arb.voice_cycle == SLOT_START) && !fifo_empty
                        && !cpu_active && !arb.cpu_bus_i.res;
    // The aux write only owns the bus while the CPU is quiet and the pipeline
    // is inside the hold window; anything else falls back to passthrough.
    assign override   = (state == ARB_INJECT) && !cpu_active && in_window;
    // Retire the head only after it has been held through the whole window.
    assign fifo_pop   = override && (arb.voice_cycle == INJ_LAST);

    // Slot FSM and saturating preemption counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            preempt_q <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (slot_free) state <= ARB_INJECT;
                end
                ARB_INJECT: begin
                    if (cpu_active) begin
                        // Head stays queued; the retry rewrites the same value.
                        state <= ARB_IDLE;
                        if (preempt_q != 8'hFF) preempt_q <= preempt_q + 8'd1;
                    end else if (!in_window || (arb.voice_cycle == INJ_LAST)) begin
                        state <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    // Output mux: CPU passthrough unless an uncontested injection is active.
    always_comb begin
        arb.bus_o = arb.cpu_bus_i;
        arb.cs_o  = arb.cpu_cs;
        if (override) begin
            arb.bus_o.phi2  = 1'b0;
            arb.bus_o.res   = arb.cpu_bus_i.res;
            arb.bus_o.r_w_n = 1'b0;
            arb.bus_o.addr  = head.addr;
            arb.bus_o.data  = head.data;
            arb.cs_o        = chip_cs(head.chip);
        end
    end

    assign arb.aux_ready   = !fifo_full;
    assign arb.busy        = (state == ARB_INJECT);
    assign arb.preempt_cnt = preempt_q;

endmodule

// File: tb/tb_sid_bus_arbiter.sv
// Directed and randomized bench for sid_bus_arbiter against a queue-based
// reference of the slot arbitration rules.
module tb_sid_bus_arbiter;
    import sid_bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sid_bus_arbiter_if arb();

    sid_bus_arbiter #(.FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb.slave)
    );

    aux_wr_t mq[$];
    bit      m_inj;
    int      m_pcnt;
    int      vc;
    int      n_assert = 0;
    int      n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs();
        bus_i_t     eb;
        logic [1:0] ecs;
        bit         owned;
        owned = m_inj && (arb.cpu_cs == 2'b00) && (vc >= 1) && (vc <= 6);
        eb  = arb.cpu_bus_i;
        ecs = arb.cpu_cs;
        if (owned) begin
            eb.phi2  = 1'b0;
            eb.r_w_n = 1'b0;
            eb.addr  = mq[0].addr;
            eb.data  = mq[0].data;
            ecs      = mq[0].chip ? 2'b10 : 2'b01;
        end
        check("bus_o", 32'(arb.bus_o), 32'(eb));
        check("cs_o", 32'(arb.cs_o), 32'(ecs));
        check("busy", 32'(arb.busy), 32'(m_inj));
        check("aux_ready", 32'(arb.aux_ready), 32'(mq.size() < 8));
        check("preempt_cnt", 32'(arb.preempt_cnt), 32'(m_pcnt));
    endtask

    task automatic model_edge();
        bit      pushed;
        aux_wr_t w;
        if (!rst_n) begin
            mq.delete();
            m_inj  = 0;
            m_pcnt = 0;
        end else begin
            pushed = arb.aux_valid && (mq.size() < 8);
            w      = arb.aux_wr;
            if (m_inj) begin
                if (arb.cpu_cs != 2'b00) begin
                    m_inj = 0;
                    if (m_pcnt < 255) m_pcnt++;
                end else if (vc == 6) begin
                    void'(mq.pop_front());
                    m_inj = 0;
                end
            end else if (vc == 0 && mq.size() > 0 && arb.cpu_cs == 2'b00 && !arb.cpu_bus_i.res) begin
                m_inj = 1;
            end
            if (pushed) mq.push_back(w);
        end
    endtask

    task automatic cycle(input bit do_chk);
        #1;
        if (do_chk) compare_outputs();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        vc = (vc == 12) ? 0 : vc + 1;
        arb.voice_cycle = cycle_t'(vc);
    endtask

    task automatic wait_vc(input int v);
        while (vc != v) cycle(1);
    endtask

    task automatic push(input logic chip, input logic [4:0] addr, input logic [7:0] data);
        arb.aux_valid = 1'b1;
        arb.aux_wr    = '{chip: chip, addr: addr, data: data};
        cycle(1);
        arb.aux_valid = 1'b0;
    endtask

    initial begin
        bus_i_t cb;
        vc              = 0;
        arb.voice_cycle = 4'd0;
        arb.cpu_bus_i   = '{phi2: 1'b1, res: 1'b0, r_w_n: 1'b1, addr: 5'h00, data: 8'h00};
        arb.cpu_cs      = 2'b00;
        arb.aux_valid   = 1'b0;
        arb.aux_wr      = '0;
        m_inj = 0;
        m_pcnt = 0;
        rst_n = 1'b0;
        repeat (3) cycle(0);
        rst_n = 1'b1;
        #1;
        check("rst_busy", 32'(arb.busy), 32'd0);
        check("rst_ready", 32'(arb.aux_ready), 32'd1);
        check("rst_preempt", 32'(arb.preempt_cnt), 32'd0);
        check("rst_bus_pass", 32'(arb.bus_o), 32'(arb.cpu_bus_i));

        // Volume write to SID1, held for voice cycles 1..6 only.
        wait_vc(12);
        push(1'b0, 5'h18, 8'h0F);
        wait_vc(3);
        check("t1_addr", 32'(arb.bus_o.addr), 32'h18);
        check("t1_data", 32'(arb.bus_o.data), 32'h0F);
        check("t1_phi2", 32'(arb.bus_o.phi2), 32'd0);
        check("t1_rwn", 32'(arb.bus_o.r_w_n), 32'd0);
        check("t1_cs", 32'(arb.cs_o), 32'h1);
        wait_vc(7);
        check("t1_done_busy", 32'(arb.busy), 32'd0);
        check("t1_done_cs", 32'(arb.cs_o), 32'h0);

        // Write to SID2 selects cs bit 1.
        wait_vc(12);
        push(1'b1, 5'h00, 8'h55);
        wait_vc(2);
        check("t2_cs", 32'(arb.cs_o), 32'h2);
        check("t2_data", 32'(arb.bus_o.data), 32'h55);
        wait_vc(7);

        // Nine back-to-back pushes into an 8-deep queue.
        for (int i = 0; i < 9; i++) begin
            arb.aux_valid = 1'b1;
            arb.aux_wr    = '{chip: i[0], addr: 5'(i + 1), data: 8'(8'hA0 + i)};
            if (i == 8) check("t3_full_ready", 32'(arb.aux_ready), 32'd0);
            cycle(1);
        end
        arb.aux_valid = 1'b0;
        repeat (9 * 13 + 13) cycle(1);
        check("t3_drained_busy", 32'(arb.busy), 32'd0);
        check("t3_drained_ready", 32'(arb.aux_ready), 32'd1);

        // CPU write at the slot start blocks the injection for one period.
        wait_vc(12);
        push(1'b0, 5'h04, 8'h11);
        cb = '{phi2: 1'b1, res: 1'b0, r_w_n: 1'b0, addr: 5'h04, data: 8'h21};
        arb.cpu_bus_i = cb;
        arb.cpu_cs    = 2'b01;
        #1;
        check("t4_cpu_pass", 32'(arb.bus_o), 32'(cb));
        check("t4_cpu_cs", 32'(arb.cs_o), 32'h1);
        cycle(1);
        arb.cpu_cs    = 2'b00;
        arb.cpu_bus_i = '{phi2: 1'b1, res: 1'b0, r_w_n: 1'b1, addr: 5'h00, data: 8'h00};
        #1;
        check("t4_no_inject", 32'(arb.busy), 32'd0);
        wait_vc(0);
        wait_vc(2);
        check("t4_late_busy", 32'(arb.busy), 32'd1);
        check("t4_late_data", 32'(arb.bus_o.data), 32'h11);
        wait_vc(7);

        // CPU preempts an injection at voice cycle 3.
        wait_vc(12);
        push(1'b0, 5'h0B, 8'h41);
        wait_vc(3);
        cb = '{phi2: 1'b1, res: 1'b0, r_w_n: 1'b0, addr: 5'h02, data: 8'h77};
        arb.cpu_bus_i = cb;
        arb.cpu_cs    = 2'b10;
        #1;
        check("t5_preempt_bus", 32'(arb.bus_o), 32'(cb));
        cycle(1);
        arb.cpu_cs    = 2'b00;
        arb.cpu_bus_i = '{phi2: 1'b1, res: 1'b0, r_w_n: 1'b1, addr: 5'h00, data: 8'h00};
        #1;
        check("t5_busy_after", 32'(arb.busy), 32'd0);
        check("t5_preempt_cnt", 32'(arb.preempt_cnt), 32'd1);
        wait_vc(0);
        wait_vc(2);
        check("t5_retry_addr", 32'(arb.bus_o.addr), 32'h0B);
        check("t5_retry_data", 32'(arb.bus_o.data), 32'h41);
        wait_vc(7);

        // Reset in the middle of an injection with more entries queued.
        wait_vc(9);
        for (int i = 0; i < 4; i++) push(1'b1, 5'(5'h10 + i), 8'(8'hC0 + i));
        wait_vc(4);
        rst_n = 1'b0;
        cycle(1);
        rst_n = 1'b1;
        #1;
        check("t6_busy", 32'(arb.busy), 32'd0);
        check("t6_ready", 32'(arb.aux_ready), 32'd1);
        check("t6_preempt", 32'(arb.preempt_cnt), 32'd0);
        check("t6_bus_pass", 32'(arb.bus_o), 32'(arb.cpu_bus_i));
        repeat (26) cycle(1);

        // Random traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(199) != 0);
            arb.aux_valid = $urandom_range(1);
            arb.aux_wr    = aux_wr_t'($urandom);
            arb.cpu_cs    = ($urandom_range(5) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            cb            = bus_i_t'($urandom);
            cb.res        = ($urandom_range(9) == 0);
            arb.cpu_bus_i = cb;
            cycle(1);
        end
        rst_n         = 1'b1;
        arb.aux_valid = 1'b0;
        arb.cpu_cs    = 2'b00;
        arb.cpu_bus_i = '{phi2: 1'b1, res: 1'b0, r_w_n: 1'b1, addr: 5'h00, data: 8'h00};

        // Repeated preemption drives the counter into saturation.
        rst_n = 1'b0;
        cycle(1);
        rst_n = 1'b1;
        wait_vc(12);
        push(1'b0, 5'h01, 8'h33);
        for (int i = 0; i < 270; i++) begin
            wait_vc(2);
            arb.cpu_cs = 2'b01;
            cycle(1);
            arb.cpu_cs = 2'b00;
        end
        #1;
        check("sat_preempt", 32'(arb.preempt_cnt), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
